// File: rtl/pieo_deq_ctrl.sv
// pieo_deq_ctrl: issues per-timeslot PIEO dequeue bursts and buffers the unpacked cells for the cell scheduler
module pieo_deq_ctrl #(
  parameter int ELEM_W = 14,
  parameter int TIME_W = 2,
  parameter int NULL_BUCKET = 1,
  parameter int MAX_DEQ_PER_SLOT = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              slot_start,
  input  logic [TIME_W-1:0] eligible_bitmap,
  input  logic              pieo_ready,
  output logic              pieo_deq_req,
  output logic [TIME_W-1:0] pieo_curr_time,
  input  logic              pieo_deq_valid,
  input  logic [ELEM_W-1:0] pieo_deq_elem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_id,
  output logic [2:0]        out_slot,
  output logic [2:0]        out_send_time,
  output logic [2:0]        out_rem_hops,
  output logic              out_is_spray,
  output logic              slot_done,
  output logic              overrun,
  output logic              timeout_err,
  output logic [7:0]        deq_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TIME_W-1:0] MASK = ~(TIME_W'(1) << NULL_BUCKET);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] credits;
  logic [TW-1:0] timer;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [12:0] mem [FIFO_DEPTH];
  logic resp_null, push, pop, tmo;
  assign resp_null = pieo_deq_elem[6:4] == 3'(NULL_BUCKET);
  assign push = state == WAIT && pieo_deq_valid && !resp_null;
  assign out_valid = fifo_count != '0;
  assign pop = out_valid && out_ready;
  assign tmo = state == WAIT && !pieo_deq_valid && timer == TW'(TIMEOUT - 1);
  assign slot_done = state == DONE;
  assign {out_id, out_slot, out_send_time, out_rem_hops, out_is_spray} = mem[rd_ptr];
  always_comb begin
    state_nx = state;
    pieo_deq_req = 1'b0;
    case (state)
      IDLE:  state_nx = slot_start ? ISSUE : IDLE;
      ISSUE: begin
        pieo_deq_req = pieo_ready && fifo_count < CW'(FIFO_DEPTH);
        state_nx = pieo_deq_req ? WAIT : ISSUE;
      end
      WAIT:  state_nx = pieo_deq_valid ? ((resp_null || credits == 4'd1) ? DONE : ISSUE) : (tmo ? DONE : WAIT);
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      credits <= '0;
      timer <= '0;
      pieo_curr_time <= '0;
      fifo_count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      overrun <= 1'b0;
      timeout_err <= 1'b0;
      deq_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && slot_start) begin
        pieo_curr_time <= eligible_bitmap & MASK;
        credits <= 4'(MAX_DEQ_PER_SLOT);
      end
      timer <= pieo_deq_req ? '0 : (state == WAIT ? timer + 1'b1 : timer);
      if (slot_start && state != IDLE) overrun <= 1'b1;
      if (tmo) timeout_err <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= {pieo_deq_elem[13:8], pieo_deq_elem[6:0]};
        wr_ptr <= wr_ptr + 1'b1;
        credits <= credits - 1'b1;
        deq_count <= deq_count + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_pieo_deq_ctrl.sv
// tb_pieo_deq_ctrl: directed and randomized checks of pieo_deq_ctrl against a queue-based behavioural model
module tb_pieo_deq_ctrl;
  logic clk = 0, rst_n = 0, slot_start = 0, pieo_ready = 0, pieo_deq_valid = 0, out_ready = 0;
  logic [1:0] eligible_bitmap = 0;
  logic [13:0] pieo_deq_elem = 0;
  logic pieo_deq_req, out_valid, out_is_spray, slot_done, overrun, timeout_err;
  logic [1:0] pieo_curr_time;
  logic [2:0] out_id, out_slot, out_send_time, out_rem_hops;
  logic [7:0] deq_count;
  int total = 0, bad = 0;
  int mq[$];
  bit busy, waiting, ending, ovr, tmo;
  int wcnt, cred, ctime, dcnt;

  pieo_deq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .slot_start(slot_start), .eligible_bitmap(eligible_bitmap),
    .pieo_ready(pieo_ready), .pieo_deq_req(pieo_deq_req), .pieo_curr_time(pieo_curr_time),
    .pieo_deq_valid(pieo_deq_valid), .pieo_deq_elem(pieo_deq_elem), .out_valid(out_valid),
    .out_ready(out_ready), .out_id(out_id), .out_slot(out_slot), .out_send_time(out_send_time),
    .out_rem_hops(out_rem_hops), .out_is_spray(out_is_spray), .slot_done(slot_done),
    .overrun(overrun), .timeout_err(timeout_err), .deq_count(deq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] mk(int id, int sl, int rk, int st, int rm, int sp);
    return 14'(((id & 7) << 11) | ((sl & 7) << 8) | ((rk & 1) << 7) | ((st & 7) << 4) | ((rm & 7) << 1) | (sp & 1));
  endfunction

  function automatic bit m_req();
    return busy && !waiting && !ending && pieo_ready && mq.size() < 4;
  endfunction

  task automatic model_reset();
    mq.delete();
    {busy, waiting, ending, ovr, tmo} = '0;
    wcnt = 0; cred = 0; ctime = 0; dcnt = 0;
  endtask

  // one clock of the reference behaviour, evaluated from the inputs present at the edge
  task automatic model_clk();
    bit pop, req;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pop = mq.size() != 0 && out_ready;
    req = m_req();
    if (slot_start && busy) ovr = 1;
    if (pop) void'(mq.pop_front());
    if (ending) begin
      ending = 0; busy = 0;
    end else if (!busy) begin
      if (slot_start) begin busy = 1; ctime = eligible_bitmap & ~(1 << 1); cred = 2; end
    end else if (!waiting) begin
      if (req) begin waiting = 1; wcnt = 0; end
    end else if (pieo_deq_valid) begin
      waiting = 0;
      if (((pieo_deq_elem >> 4) & 7) == 1) ending = 1;
      else begin
        mq.push_back(pieo_deq_elem);
        dcnt++; cred--;
        if (cred == 0) ending = 1;
      end
    end else if (wcnt == 7) begin
      tmo = 1; ending = 1; waiting = 0;
    end else wcnt++;
  endtask

  task automatic compare();
    int h;
    h = mq.size() != 0 ? mq[0] : 0;
    chk("deq_req", pieo_deq_req, m_req());
    chk("curr_time", pieo_curr_time, ctime);
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("out_id", out_id, (h >> 11) & 7);
      chk("out_slot", out_slot, (h >> 8) & 7);
      chk("out_send_time", out_send_time, (h >> 4) & 7);
      chk("out_rem_hops", out_rem_hops, (h >> 1) & 7);
      chk("out_is_spray", out_is_spray, h & 1);
    end
    chk("slot_done", slot_done, ending);
    chk("overrun", overrun, ovr);
    chk("timeout_err", timeout_err, tmo);
    chk("deq_count", deq_count, dcnt & 255);
  endtask

  task automatic step();
    #4;
    compare();
    @(posedge clk);
    model_clk();
    @(negedge clk);
  endtask

  task automatic resp(logic [13:0] e);
    pieo_deq_valid = 1; pieo_deq_elem = e;
    step();
    pieo_deq_valid = 0;
  endtask

  task automatic burst2(int a, int b);
    slot_start = 1; step(); slot_start = 0;
    step();
    resp(mk(a, 2, 1, 0, 3, 1));
    step();
    resp(mk(b, 5, 0, 2, 6, 0));
    step();
  endtask

  initial begin
    int pend, pcnt;
    bit issued;
    model_reset();
    @(negedge clk);
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_deq_count", deq_count, 0);
    rst_n = 1; pieo_ready = 1; out_ready = 1;
    eligible_bitmap = 2'b11; slot_start = 1; step(); slot_start = 0;
    chk("lit_req1", pieo_deq_req, 1);
    chk("lit_ctime", pieo_curr_time, 1);
    step();
    resp(mk(5, 3, 1, 0, 2, 1));
    chk("lit_id5", out_id, 5);
    chk("lit_valid1", out_valid, 1);
    chk("lit_ctime2", pieo_curr_time, 1);
    step();
    resp(mk(2, 1, 0, 0, 4, 0));
    chk("lit_id2", out_id, 2);
    chk("lit_done", slot_done, 1);
    chk("lit_cnt2", deq_count, 2);
    step();
    eligible_bitmap = 2'b01; slot_start = 1; step(); slot_start = 0;
    step();
    resp(mk(7, 7, 1, 1, 7, 1));
    chk("null_done", slot_done, 1);
    chk("null_valid", out_valid, 0);
    chk("null_cnt", deq_count, 2);
    step();
    chk("null_noreq", pieo_deq_req, 0);
    out_ready = 0;
    burst2(1, 4);
    burst2(6, 3);
    slot_start = 1; step(); slot_start = 0;
    repeat (3) step();
    chk("bp_noreq", pieo_deq_req, 0);
    chk("bp_head_id", out_id, 1);
    chk("bp_cnt6", deq_count, 6);
    out_ready = 1; step(); out_ready = 0;
    chk("bp_req", pieo_deq_req, 1);
    step();
    resp(mk(2, 0, 0, 5, 1, 1));
    chk("bp_hold", pieo_deq_req, 0);
    out_ready = 1;
    step(); step();
    resp(mk(4, 4, 1, 3, 2, 0));
    step();
    repeat (6) step();
    slot_start = 1; step(); slot_start = 0;
    step();
    slot_start = 1; step(); slot_start = 0;
    chk("ovr", overrun, 1);
    chk("tmo_early", timeout_err, 0);
    repeat (6) step();
    chk("tmo_not_yet", timeout_err, 0);
    step();
    chk("tmo", timeout_err, 1);
    chk("tmo_done", slot_done, 1);
    step();
    chk("tmo_idle_done", slot_done, 0);
    slot_start = 1; step(); slot_start = 0;
    chk("after_tmo_req", pieo_deq_req, 1);
    step();
    resp(mk(3, 3, 0, 0, 0, 0));
    step();
    resp(mk(1, 1, 1, 0, 1, 1));
    step();
    out_ready = 0;
    burst2(5, 7);
    slot_start = 1; step(); slot_start = 0;
    step();
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_id", out_id, 0);
    chk("arst_cnt", deq_count, 0);
    chk("arst_ovr", overrun, 0);
    chk("arst_tmo", timeout_err, 0);
    chk("arst_ctime", pieo_curr_time, 0);
    @(negedge clk);
    step();
    rst_n = 1;
    resp(mk(6, 6, 1, 0, 6, 1));
    chk("late_cnt", deq_count, 0);
    chk("late_valid", out_valid, 0);
    pend = 0; pcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      slot_start = ($urandom % 12) == 0;
      eligible_bitmap = 2'($urandom);
      pieo_ready = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      pieo_deq_valid = 0;
      if (pend != 0 && pcnt == 0) begin
        pieo_deq_valid = 1;
        pieo_deq_elem = mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        pend = 0;
      end else if (pend != 0) pcnt--;
      issued = m_req();
      step();
      if (issued && ($urandom % 8) != 0) begin
        pend = 1; pcnt = $urandom_range(0, 7);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
